// File: rtl/stream_mux_pkg.sv
// Shared types for the round-robin stream multiplexer: selection mode and
// packet-lock FSM states.
package stream_mux_pkg;

    typedef enum logic {
        MODE_SEL = 1'b0,
        MODE_RR  = 1'b1
    } mode_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_LOCK = 1'b1
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority arbiter: grants the first requesting channel
// found searching upward from ptr+1 with wrap-around.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic             gnt_vld,
    output logic [SEL_W-1:0] gnt_idx
);

    logic [SEL_W-1:0] cand;

    // Walk from the farthest candidate to the nearest so the nearest requester wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int i = N_CH; i >= 1; i--) begin
            cand = SEL_W'((int'(ptr) + i) % N_CH);
            if (req[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel packet-aware stream multiplexer with explicit or round-robin
// selection, packet grant locking and a one-entry registered output.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int DATA_W = 16,
    parameter int SEL_W  = $clog2(N_CH)
) (
    input  logic                   clk,
    input  logic                   RST,
    input  logic                   mode,
    input  logic [SEL_W-1:0]       sel,
    input  logic [N_CH*DATA_W-1:0] in_data,
    input  logic [N_CH-1:0]        in_valid,
    input  logic [N_CH-1:0]        in_last,
    output logic [N_CH-1:0]        in_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic                   out_last,
    output logic [SEL_W-1:0]       out_ch,
    output logic                   out_valid,
    input  logic                   out_ready
);

    state_e            state_q, state_d;
    logic [SEL_W-1:0]  cur_q;
    logic [SEL_W-1:0]  ptr_q;
    logic              load_en;
    logic              rr_vld;
    logic [SEL_W-1:0]  rr_idx;
    logic              sel_vld;
    logic              gnt_vld;
    logic [SEL_W-1:0]  gnt_idx;
    logic [DATA_W-1:0] gnt_data;
    logic              gnt_valid_in;
    logic              gnt_last;
    logic              accept;

    rr_arbiter #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_arb (
        .req     (in_valid),
        .ptr     (ptr_q),
        .gnt_vld (rr_vld),
        .gnt_idx (rr_idx)
    );

    assign load_en = !out_valid || out_ready;

    // Out-of-range selects never match a channel, so they yield no grant.
    always_comb begin
        sel_vld = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (sel == SEL_W'(k) && in_valid[k]) begin
                sel_vld = 1'b1;
            end
        end
    end

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        if (state_q == S_LOCK) begin
            gnt_vld = 1'b1;
            gnt_idx = cur_q;
        end else if (mode_e'(mode) == MODE_RR) begin
            gnt_vld = rr_vld;
            gnt_idx = rr_idx;
        end else begin
            gnt_vld = sel_vld;
            gnt_idx = sel;
        end
    end

    always_comb begin
        gnt_data     = '0;
        gnt_valid_in = 1'b0;
        gnt_last     = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (gnt_idx == SEL_W'(k)) begin
                gnt_data     = in_data[k*DATA_W +: DATA_W];
                gnt_valid_in = in_valid[k];
                gnt_last     = in_last[k];
            end
        end
    end

    // Ready is held low while reset is asserted even though the output is empty.
    always_comb begin
        in_ready = '0;
        state_d  = state_q;
        for (int k = 0; k < N_CH; k++) begin
            if (RST && gnt_vld && load_en && gnt_idx == SEL_W'(k)) begin
                in_ready[k] = 1'b1;
            end
        end
        accept = RST && gnt_vld && load_en && gnt_valid_in;
        case (state_q)
            S_IDLE:  if (accept && !gnt_last) state_d = S_LOCK;
            S_LOCK:  if (accept && gnt_last)  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            cur_q   <= '0;
            ptr_q   <= SEL_W'(N_CH - 1);
        end else begin
            state_q <= state_d;
            if (accept && state_q == S_IDLE && !gnt_last) begin
                cur_q <= gnt_idx;
            end
            if (accept && gnt_last) begin
                ptr_q <= gnt_idx;
            end
        end
    end

    // Data registers keep their last beat when the output drains.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            out_data  <= '0;
            out_last  <= 1'b0;
            out_ch    <= '0;
            out_valid <= 1'b0;
        end else if (accept) begin
            out_data  <= gnt_data;
            out_last  <= gnt_last;
            out_ch    <= gnt_idx;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr: constant vector table, directed
// packet sequences and randomized traffic against a behavioural model.
module tb_stream_mux_rr;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mode;
    logic [SW-1:0] sel;
    logic [W-1:0]  din [N];
    logic [N*W-1:0] in_data;
    logic [N-1:0]  in_valid, in_last, in_ready;
    logic [W-1:0]  out_data;
    logic          out_last, out_valid, out_ready;
    logic [SW-1:0] out_ch;

    logic          mode3;
    logic [1:0]    sel3;
    logic [47:0]   in_data3;
    logic [2:0]    in_valid3, in_last3, in_ready3;
    logic [15:0]   out_data3;
    logic          out_last3, out_valid3, out_ready3;
    logic [1:0]    out_ch3;

    int n_cmp = 0;
    int n_err = 0;

    bit            m_locked;
    int            m_cur, m_ptr, m_och;
    bit            m_ov, m_ol;
    logic [W-1:0]  m_od;

    always #5 clk = ~clk;

    assign in_data = {din[3], din[2], din[1], din[0]};

    stream_mux_rr #(.N_CH(N), .DATA_W(W)) dut (
        .clk(clk), .RST(rst_n), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .out_data(out_data), .out_last(out_last), .out_ch(out_ch),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    stream_mux_rr #(.N_CH(3), .DATA_W(16)) dut3 (
        .clk(clk), .RST(rst_n), .mode(mode3), .sel(sel3),
        .in_data(in_data3), .in_valid(in_valid3), .in_last(in_last3), .in_ready(in_ready3),
        .out_data(out_data3), .out_last(out_last3), .out_ch(out_ch3),
        .out_valid(out_valid3), .out_ready(out_ready3)
    );

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  last;
        logic [15:0] d2;
        logic [3:0]  exp_ready;
        logic        exp_ov;
        logic [15:0] exp_od;
        logic [1:0]  exp_och;
        logic        exp_ol;
    } vec_t;

    vec_t vecs [5];

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int rr_pick(input int p, input logic [N-1:0] v);
        for (int i = 1; i <= N; i++) begin
            if (v[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    function automatic int model_grant();
        if (!rst_n) return -1;
        if (m_locked) return m_cur;
        if (mode) return rr_pick(m_ptr, in_valid);
        if (int'(sel) < N && in_valid[sel]) return int'(sel);
        return -1;
    endfunction

    function automatic logic [N-1:0] model_ready();
        logic [N-1:0] r;
        int g;
        r = '0;
        g = model_grant();
        if (g >= 0 && (!m_ov || out_ready)) r[g] = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        m_locked = 0; m_cur = 0; m_ptr = N - 1;
        m_ov = 0; m_od = '0; m_ol = 0; m_och = 0;
    endtask

    task automatic model_edge();
        int g;
        g = model_grant();
        if (g >= 0 && (!m_ov || out_ready) && in_valid[g]) begin
            m_od  = din[g];
            m_ol  = in_last[g];
            m_och = g;
            m_ov  = 1;
            if (in_last[g]) begin
                m_locked = 0;
                m_ptr    = g;
            end else begin
                m_locked = 1;
                m_cur    = g;
            end
        end else if (m_ov && out_ready) begin
            m_ov = 0;
        end
    endtask

    task automatic check_output(input string tag);
        check_val({tag, ".in_ready"},  32'(in_ready),  32'(model_ready()));
        check_val({tag, ".out_valid"}, 32'(out_valid), 32'(m_ov));
        check_val({tag, ".out_data"},  32'(out_data),  32'(m_od));
        check_val({tag, ".out_last"},  32'(out_last),  32'(m_ol));
        check_val({tag, ".out_ch"},    32'(out_ch),    32'(m_och));
    endtask

    task automatic wait_sample(input string tag);
        @(negedge clk);
        check_output(tag);
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
    endtask

    task automatic apply_stimulus(input string tag);
        wait_sample(tag);
        advance();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [15:0] hold_d;
        logic [1:0]  hold_c;

        vecs[0] = '{4'b0101, 4'b0000, 16'h00A1, 4'b0100, 1'b0, 16'h0000, 2'd0, 1'b0};
        vecs[1] = '{4'b0101, 4'b0000, 16'h00A2, 4'b0100, 1'b1, 16'h00A1, 2'd2, 1'b0};
        vecs[2] = '{4'b0101, 4'b0100, 16'h00A3, 4'b0100, 1'b1, 16'h00A2, 2'd2, 1'b0};
        vecs[3] = '{4'b0001, 4'b0000, 16'h00A3, 4'b0000, 1'b1, 16'h00A3, 2'd2, 1'b1};
        vecs[4] = '{4'b0001, 4'b0000, 16'h00A3, 4'b0000, 1'b0, 16'h00A3, 2'd2, 1'b1};

        mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111; in_last3 = 3'b111;
        in_data3 = 48'h0003_0002_0001; out_ready3 = 1'b1;

        rst_n = 1'b0;
        model_reset();
        mode = 1'b0; sel = 2'd2; out_ready = 1'b1;
        in_valid = 4'b1111; in_last = 4'b0000;
        din[0] = 16'h00B0; din[1] = 16'h00B1; din[2] = 16'h00A1; din[3] = 16'h00B3;

        // Reset state, with every channel requesting.
        wait_sample("reset");
        check_val("reset.in_ready_zero", 32'(in_ready), 32'd0);
        check_val("reset.out_valid_zero", 32'(out_valid), 32'd0);
        advance();
        apply_stimulus("reset2");
        rst_n = 1'b1;

        // Explicit select of ch2 with ch0 competing.
        for (int i = 0; i < 5; i++) begin
            in_valid = vecs[i].valid;
            in_last  = vecs[i].last;
            din[2]   = vecs[i].d2;
            wait_sample("tbl");
            check_val($sformatf("tbl[%0d].in_ready", i),  32'(in_ready),  32'(vecs[i].exp_ready));
            check_val($sformatf("tbl[%0d].out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
            check_val($sformatf("tbl[%0d].out_data", i),  32'(out_data),  32'(vecs[i].exp_od));
            check_val($sformatf("tbl[%0d].out_ch", i),    32'(out_ch),    32'(vecs[i].exp_och));
            check_val($sformatf("tbl[%0d].out_last", i),  32'(out_last),  32'(vecs[i].exp_ol));
            advance();
        end

        // Round-robin single-beat packets from a fresh reset.
        rst_n = 1'b0;
        model_reset();
        apply_stimulus("rr_rst");
        rst_n = 1'b1;
        mode = 1'b1; in_valid = 4'b1111; in_last = 4'b1111; out_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            for (int c = 0; c < N; c++) din[c] = 16'(16'h1000 + k * 16 + c);
            wait_sample("rr");
            if (k >= 1) begin
                check_val($sformatf("rr[%0d].order", k), 32'(out_ch), 32'((k - 1) % N));
                check_val($sformatf("rr[%0d].no_gap", k), 32'(out_valid), 32'd1);
            end
            advance();
        end

        // Packet lock on ch1 while mode flips to explicit select of ch0.
        sel = 2'd0;
        din[0] = 16'h00D0; din[3] = 16'h00D3;
        for (int p = 0; p < 6; p++) begin
            in_valid = (p == 0) ? 4'b0010 : (p <= 3) ? 4'b1011 : 4'b1001;
            in_last  = (p == 3) ? 4'b0010 : (p >= 4) ? 4'b1001 : 4'b0000;
            if (p <= 3) din[1] = 16'(16'h00C1 + p);
            if (p >= 1) mode = 1'b0;
            wait_sample("lock");
            if (p >= 1 && p <= 4) begin
                check_val($sformatf("lock[%0d].ch", p),   32'(out_ch),   32'd1);
                check_val($sformatf("lock[%0d].data", p), 32'(out_data), 32'(16'h00C0 + p));
                check_val($sformatf("lock[%0d].last", p), 32'(out_last), 32'(p == 4));
            end
            if (p >= 1 && p <= 3) check_val($sformatf("lock[%0d].ready", p), 32'(in_ready), 32'b0010);
            if (p == 5) begin
                check_val("lock.after_ch", 32'(out_ch), 32'd0);
                check_val("lock.after_data", 32'(out_data), 32'h00D0);
            end
            advance();
        end

        // Backpressure for five cycles with a beat held in the output register.
        mode = 1'b1; in_valid = 4'b1111; in_last = 4'b1111; out_ready = 1'b1;
        for (int c = 0; c < N; c++) din[c] = 16'(16'h2000 + c);
        apply_stimulus("bp_pre");
        out_ready = 1'b0;
        hold_d = '0;
        hold_c = '0;
        for (int s = 0; s < 5; s++) begin
            wait_sample("bp");
            if (s == 0) begin
                hold_d = out_data;
                hold_c = out_ch;
            end else begin
                check_val($sformatf("bp[%0d].data_stable", s), 32'(out_data), 32'(hold_d));
                check_val($sformatf("bp[%0d].ch_stable", s),   32'(out_ch),   32'(hold_c));
            end
            check_val($sformatf("bp[%0d].ready_zero", s), 32'(in_ready), 32'd0);
            check_val($sformatf("bp[%0d].valid_held", s), 32'(out_valid), 32'd1);
            advance();
        end
        out_ready = 1'b1;
        apply_stimulus("bp_post0");
        apply_stimulus("bp_post1");

        // Out-of-range select on the three-channel instance.
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            check_val($sformatf("badsel[%0d].ready", s), 32'(in_ready3), 32'd0);
            check_val($sformatf("badsel[%0d].valid", s), 32'(out_valid3), 32'd0);
            advance();
        end

        // Asynchronous reset during beat 2 of a 4-beat ch2 packet.
        mode = 1'b1; in_valid = 4'b0100; in_last = 4'b0000; din[2] = 16'h00E1;
        apply_stimulus("arst_b1");
        din[2] = 16'h00E2;
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_val("arst.out_valid_now", 32'(out_valid), 32'd0);
        check_val("arst.in_ready_now",  32'(in_ready),  32'd0);
        wait_sample("arst_hold");
        advance();
        rst_n = 1'b1;
        in_valid = 4'b1111; in_last = 4'b1111;
        for (int c = 0; c < N; c++) din[c] = 16'(16'h3000 + c);
        apply_stimulus("arst_rel");
        wait_sample("arst_next");
        check_val("arst.next_ch", 32'(out_ch), 32'd0);
        check_val("arst.next_valid", 32'(out_valid), 32'd1);
        advance();

        // Randomized traffic against the model.
        for (int r = 0; r < 400; r++) begin
            mode      = 1'($urandom_range(0, 1));
            sel       = 2'($urandom_range(0, 3));
            in_valid  = 4'($urandom_range(0, 15));
            in_last   = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < N; c++) din[c] = 16'($urandom);
            apply_stimulus("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
